prga: RTL and testbench

PRGA -- requirements
Module: prga

---
 rtl/prga_if.sv | 30 +++
 rtl/prga.sv | 111 +++++++++++
 tb/tb_prga.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/prga_if.sv
// prga_if -- bus bundle for the prga RC4-style decryptor.
//   en/rdy      : start handshake (en sampled only while rdy=1)
//   s_*         : S-box memory port (sync read, addr N -> data N+1)
//   ct_*        : ciphertext read port, byte 0 holds message length
//   pt_*        : plaintext write port
//   pt_bad      : sticky non-printable flag
// Modports: master = environment (drives en, read data), slave = prga.
interface prga_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;
  logic       pt_bad;

  modport master (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren, pt_bad
  );
  modport slave (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren, pt_bad
  );
endinterface

// File: rtl/prga.sv
// prga -- RC4 PRGA decryptor. Reads length byte ct[0], copies it to pt[0],
// then for k=1..len generates one keystream byte (swap in S) and writes
// pt[k] = pad ^ ct[k]. Nine cycles per byte, rdy back 5+9*len cycles after
// the accepting cycle.
// Ports: clk, rst_n (async, active-low), bus (prga_if.slave).
// Option: define PRGA_ASCII_CHECK_EN to flag written bytes k>=1 outside
// 0x20..0x7E on pt_bad (sticky until next accepted en or reset).
module prga (
  input  logic   clk,
  input  logic   rst_n,
  prga_if.slave  bus
);
  typedef enum logic [3:0] {
    IDLE, LEN_RD, LEN_WAIT, LEN_WR, SI_RD, SI_WAIT, SJ_RD, SJ_WAIT,
    WR_I, WR_J, PAD_RD, PAD_WAIT, PT_WR, DONE
  } state_t;

  state_t     r_state, w_nxt;
  logic [7:0] r_i, r_j, r_k, r_len, r_si, r_sj, r_pad, r_ct;
  logic [7:0] w_i1, w_jsum, w_padaddr, w_pt;
  logic       w_start;

  assign w_i1      = r_i + 8'd1;
  assign w_jsum    = r_j + r_si;
  // After the swap S[i]=sj and S[j]=si, so the pad index is the same sum.
  assign w_padaddr = r_si + r_sj;
  assign w_pt      = r_pad ^ r_ct;
  assign w_start   = (r_state == IDLE) && bus.en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i <= '0; r_j <= '0; r_k <= '0; r_len <= '0;
      r_si <= '0; r_sj <= '0; r_pad <= '0; r_ct <= '0;
    end else begin
      case (r_state)
        IDLE:     if (bus.en) begin r_i <= '0; r_j <= '0; r_k <= 8'd1; end
        LEN_WAIT: r_len <= bus.ct_rddata;
        SI_RD:    r_i   <= w_i1;
        SI_WAIT:  r_si  <= bus.s_rddata;
        SJ_RD:    r_j   <= w_jsum;
        SJ_WAIT:  r_sj  <= bus.s_rddata;
        PAD_WAIT: begin r_pad <= bus.s_rddata; r_ct <= bus.ct_rddata; end
        PT_WR:    if (r_k != r_len) r_k <= r_k + 8'd1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    w_nxt         = r_state;
    bus.rdy       = 1'b0;
    bus.s_addr    = '0;
    bus.s_wrdata  = '0;
    bus.s_wren    = 1'b0;
    bus.ct_addr   = '0;
    bus.pt_addr   = '0;
    bus.pt_wrdata = '0;
    bus.pt_wren   = 1'b0;
    case (r_state)
      IDLE:     begin bus.rdy = 1'b1; if (bus.en) w_nxt = LEN_RD; end
      LEN_RD:   w_nxt = LEN_WAIT;
      LEN_WAIT: w_nxt = LEN_WR;
      LEN_WR: begin
        bus.pt_wrdata = r_len;
        bus.pt_wren   = 1'b1;
        w_nxt         = (r_len == 8'd0) ? DONE : SI_RD;
      end
      SI_RD:    begin bus.s_addr = w_i1;   w_nxt = SI_WAIT; end
      SI_WAIT:  w_nxt = SJ_RD;
      SJ_RD:    begin bus.s_addr = w_jsum; w_nxt = SJ_WAIT; end
      SJ_WAIT:  w_nxt = WR_I;
      WR_I: begin
        bus.s_addr = r_i; bus.s_wrdata = r_sj; bus.s_wren = 1'b1;
        w_nxt = WR_J;
      end
      WR_J: begin
        bus.s_addr = r_j; bus.s_wrdata = r_si; bus.s_wren = 1'b1;
        w_nxt = PAD_RD;
      end
      PAD_RD: begin
        bus.s_addr = w_padaddr; bus.ct_addr = r_k;
        w_nxt = PAD_WAIT;
      end
      PAD_WAIT: w_nxt = PT_WR;
      PT_WR: begin
        bus.pt_addr = r_k; bus.pt_wrdata = w_pt; bus.pt_wren = 1'b1;
        w_nxt = (r_k == r_len) ? DONE : SI_RD;
      end
      DONE:     w_nxt = IDLE;
      default:  w_nxt = IDLE;
    endcase
  end

`ifdef PRGA_ASCII_CHECK_EN
  logic r_bad;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                  r_bad <= 1'b0;
    else if (w_start)                                            r_bad <= 1'b0;
    else if (r_state == PT_WR && (w_pt < 8'h20 || w_pt > 8'h7E)) r_bad <= 1'b1;
  end
  assign bus.pt_bad = r_bad;
`else
  assign bus.pt_bad = 1'b0;
`endif

endmodule

// File: tb/tb_prga.sv
// tb_prga -- directed bench for prga with behavioural sync-read memories.
module tb_prga;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prga_if bus ();
  prga u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] s_mem  [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] s_rd, ct_rd;
  int         pt_wr_cnt, s_wr_cnt;
  logic       mem_init = 1'b0;

  assign bus.s_rddata  = s_rd;
  assign bus.ct_rddata = ct_rd;

  // Memory model; mem_init reloads identity S and clears pt + write counters.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int x = 0; x < 256; x++) begin
        s_mem[x]  <= 8'(x);
        pt_mem[x] <= 8'h00;
      end
      pt_wr_cnt <= 0;
      s_wr_cnt  <= 0;
    end else begin
      s_rd  <= s_mem[bus.s_addr];
      ct_rd <= ct_mem[bus.ct_addr];
      if (bus.s_wren)  begin s_mem[bus.s_addr] <= bus.s_wrdata; s_wr_cnt <= s_wr_cnt + 1; end
      if (bus.pt_wren) begin pt_mem[bus.pt_addr] <= bus.pt_wrdata; pt_wr_cnt <= pt_wr_cnt + 1; end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

`ifdef PRGA_ASCII_CHECK_EN
  localparam logic EXP_BAD = 1'b1;
`else
  localparam logic EXP_BAD = 1'b0;
`endif

  task automatic init_mem();
    @(negedge clk) mem_init = 1'b1;
    @(negedge clk) mem_init = 1'b0;
  endtask

  // Start a message, optionally pulse en while busy; returns cycle index at
  // which rdy returned (accepting cycle = 0).
  task automatic run_msg(input bit busy_pulse, output int lat);
    @(negedge clk) bus.en = 1'b1;
    @(posedge clk);
    #1 bus.en = 1'b0;
    lat = 1;
    chk("rdy_low_after_accept", {31'd0, bus.rdy}, 32'd0);
    chk("pt_bad_cleared",       {31'd0, bus.pt_bad}, 32'd0);
    while (!bus.rdy && lat < 5000) begin
      bus.en = busy_pulse && (lat == 3);
      @(posedge clk);
      #1 lat++;
    end
    bus.en = 1'b0;
    if (lat >= 5000) chk("rdy_timeout", 32'd1, 32'd0);
  endtask

  task automatic load_short();
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
    ct_mem[0] = 8'h02; ct_mem[1] = 8'h00; ct_mem[2] = 8'h05;
  endtask

  task automatic check_short(input string pfx, input int lat);
    chk({pfx, "_lat"},   lat, 23);
    chk({pfx, "_pt0"},   pt_mem[0], 8'h02);
    chk({pfx, "_pt1"},   pt_mem[1], 8'h02);
    chk({pfx, "_pt2"},   pt_mem[2], 8'h00);
    chk({pfx, "_s2"},    s_mem[2], 8'h03);
    chk({pfx, "_s3"},    s_mem[3], 8'h02);
    chk({pfx, "_ptcnt"}, pt_wr_cnt, 3);
    chk({pfx, "_bad"},   {31'd0, bus.pt_bad}, {31'd0, EXP_BAD});
  endtask

  initial begin
    int lat, cnt_snap, scnt_snap;
    bus.en = 1'b0;
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
    #2;
    chk("rst_rdy",    {31'd0, bus.rdy}, 32'd1);
    chk("rst_swren",  {31'd0, bus.s_wren}, 32'd0);
    chk("rst_ptwren", {31'd0, bus.pt_wren}, 32'd0);
    chk("rst_saddr",  bus.s_addr, 8'h00);
    chk("rst_ptbad",  {31'd0, bus.pt_bad}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // len = 0
    init_mem();
    run_msg(1'b0, lat);
    chk("len0_lat",   lat, 5);
    chk("len0_ptcnt", pt_wr_cnt, 1);
    chk("len0_pt0",   pt_mem[0], 8'h00);
    chk("len0_swr",   s_wr_cnt, 0);

    // short message, identity S
    init_mem();
    load_short();
    run_msg(1'b0, lat);
    check_short("short", lat);

    // en pulsed while busy must be ignored
    init_mem();
    run_msg(1'b1, lat);
    check_short("busy", lat);

    // len = 255: i stops at 0xFF, j wraps
    init_mem();
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
    ct_mem[0] = 8'hFF;
    run_msg(1'b0, lat);
    chk("long_lat",   lat, 2300);
    chk("long_ptcnt", pt_wr_cnt, 256);
    chk("long_swr",   s_wr_cnt, 510);
    chk("long_pt0",   pt_mem[0], 8'hFF);
    chk("long_pt1",   pt_mem[1], 8'h02);
    chk("long_pt2",   pt_mem[2], 8'h05);

    // async reset mid-message
    init_mem();
    @(negedge clk) bus.en = 1'b1;
    @(posedge clk);
    #1 bus.en = 1'b0;
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy",    {31'd0, bus.rdy}, 32'd1);
    chk("mid_rst_swren",  {31'd0, bus.s_wren}, 32'd0);
    chk("mid_rst_ptwren", {31'd0, bus.pt_wren}, 32'd0);
    chk("mid_rst_ptbad",  {31'd0, bus.pt_bad}, 32'd0);
    cnt_snap  = pt_wr_cnt;
    scnt_snap = s_wr_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_ptcnt", pt_wr_cnt, cnt_snap);
    chk("post_rst_swcnt", s_wr_cnt, scnt_snap);
    chk("post_rst_rdy",   {31'd0, bus.rdy}, 32'd1);

    // restart after reset from byte 0
    init_mem();
    load_short();
    run_msg(1'b0, lat);
    check_short("restart", lat);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
